exe_mem_skid_reg: RTL and testbench

Parametrised EXE→MEM pipeline register with a valid/ready handshake, an optional 2-entry skid buffer, flush, and enable gating on the outputs. It replaces the fixed, always-advancing EXE stage register. MEM-stage back-pressure (for example, a multi-cycle data memory) now stalls EXE cleanly, with no combinational ready path through the stage when `SKID=1`.

---
 rtl/exe_mem_pkg.sv | 28 ++
 rtl/exe_mem_skid_reg_slot.sv | 27 ++
 rtl/exe_mem_skid_reg.sv | 148 ++++++++++++++
 tb/tb_exe_mem_skid_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pkg.sv
// Shared types and constants for the EXE->MEM pipeline register.
package exe_mem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEST_W_DEF = 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Field order matches the flat payload vector packed by the stage.
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] st_val;
        logic [DATA_W_DEF-1:0] pc;
        logic [DEST_W_DEF-1:0] dest;
    } exe_mem_payload_t;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_t;

endpackage

// File: rtl/exe_mem_skid_reg_slot.sv
// One payload holding register: load-enabled data plus a valid bit.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         valid_nxt,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // Data is only written on load so it holds its value while the slot is invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM stage register with valid/ready handshake, optional two-entry skid and flush.
module exe_mem_skid_reg
    import exe_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic [DATA_W-1:0] ALU_result_IN,
    input  logic [DATA_W-1:0] ST_val_IN,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DEST_W-1:0] Dest_IN,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DATA_W-1:0] PC,
    output logic [DEST_W-1:0] Dest,
    output logic [1:0]        occupancy
);

    localparam int unsigned PAY_W = 3 + 3 * DATA_W + DEST_W;

    state_t           state;
    state_t           state_nxt;
    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             skid_load;
    logic             main_v;
    logic             skid_v;
    logic             main_v_nxt;
    logic             skid_v_nxt;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;

    assign in_pay = {WB_en_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val_IN, PC_IN, Dest_IN};

    // With the skid slot, ready comes straight from a flop; without it, ready looks through to MEM.
    assign in_ready  = SKID ? in_ready_q : (~main_v | out_ready);
    assign out_valid = main_v;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_v & out_ready;

    // Next-state and slot control.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_pay;
        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_nxt = S_TWO;
                end else if (out_xfer) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_xfer && skid_v) begin
                    main_load = 1'b1;
                    main_d    = skid_q;
                    state_nxt = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        // Flush discards held entries and any incoming payload; a completing output is unaffected.
        if (flush) begin
            state_nxt = S_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
        main_v_nxt = (state_nxt != S_EMPTY);
        skid_v_nxt = (state_nxt == S_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_TWO);
        end
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .valid_nxt (main_v_nxt),
        .d         (main_d),
        .q         (main_q),
        .valid     (main_v)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.W(PAY_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .valid_nxt (skid_v_nxt),
                .d         (in_pay),
                .q         (skid_q),
                .valid     (skid_v)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
            assign skid_v = 1'b0;
        end
    endgenerate

    // Enables are gated by the registered valid; data fields simply hold.
    assign WB_en      = main_v & main_q[PAY_W-1];
    assign MEM_R_EN   = main_v & main_q[PAY_W-2];
    assign MEM_W_EN   = main_v & main_q[PAY_W-3];
    assign ALU_result = main_q[DEST_W + 2 * DATA_W +: DATA_W];
    assign ST_val     = main_q[DEST_W + DATA_W +: DATA_W];
    assign PC         = main_q[DEST_W +: DATA_W];
    assign Dest       = main_q[DEST_W-1:0];
    assign occupancy  = state;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Scoreboard bench for exe_mem_skid_reg: SKID=1 instance checked via queue, SKID=0 instance directed.
module tb_exe_mem_skid_reg;
    import exe_mem_pkg::*;

    typedef struct {
        exe_mem_payload_t p;
        int               cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          stream_mode = 1'b0;
    exp_t        exp_q[$];
    exp_t        e;
    exe_mem_payload_t got;

    // SKID=1 instance signals
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic        wb_in, mr_in, mw_in, wb, mr, mw;
    logic [31:0] alu_in, st_in, pc_in, alu, st, pc;
    logic [3:0]  dest_in, dest;
    logic [1:0]  occ;

    // SKID=0 instance signals
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic        wb0, mr0, mw0;
    exe_mem_payload_t pay0;
    logic [31:0] alu0, st0, pc0;
    logic [3:0]  dest0;
    logic [1:0]  occ0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_IN(wb_in), .MEM_R_EN_IN(mr_in), .MEM_W_EN_IN(mw_in),
        .ALU_result_IN(alu_in), .ST_val_IN(st_in), .PC_IN(pc_in), .Dest_IN(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_en(wb), .MEM_R_EN(mr), .MEM_W_EN(mw),
        .ALU_result(alu), .ST_val(st), .PC(pc), .Dest(dest), .occupancy(occ)
    );

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
        .WB_en_IN(pay0.wb_en), .MEM_R_EN_IN(pay0.mem_r_en), .MEM_W_EN_IN(pay0.mem_w_en),
        .ALU_result_IN(pay0.alu_result), .ST_val_IN(pay0.st_val), .PC_IN(pay0.pc), .Dest_IN(pay0.dest),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .WB_en(wb0), .MEM_R_EN(mr0), .MEM_W_EN(mw0),
        .ALU_result(alu0), .ST_val(st0), .PC(pc0), .Dest(dest0), .occupancy(occ0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        else n_pass++;
    endtask

    function automatic exe_mem_payload_t mk(input logic [31:0] p, input logic [31:0] a, input logic [2:0] ctl);
        exe_mem_payload_t r;
        r.wb_en      = ctl[2];
        r.mem_r_en   = ctl[1];
        r.mem_w_en   = ctl[0];
        r.alu_result = a;
        r.st_val     = p ^ 32'hA5A5_0000;
        r.pc         = p;
        r.dest       = p[5:2];
        return r;
    endfunction

    // Drive one cycle of stimulus; record expectation when the stage accepts it.
    task automatic step(input logic v, input logic ordy, input logic fl, input exe_mem_payload_t p);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        wb_in     = p.wb_en;
        mr_in     = p.mem_r_en;
        mw_in     = p.mem_w_en;
        alu_in    = p.alu_result;
        st_in     = p.st_val;
        pc_in     = p.pc;
        dest_in   = p.dest;
        @(negedge clk);
        if (v && in_ready && !fl) begin
            x.p   = p;
            x.cyc = cyc;
            exp_q.push_back(x);
        end
    endtask

    // Monitor: every output transfer must match the oldest accepted payload.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got.wb_en      = wb;
            got.mem_r_en   = mr;
            got.mem_w_en   = mw;
            got.alu_result = alu;
            got.st_val     = st;
            got.pc         = pc;
            got.dest       = dest;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 128'(got), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("payload", 128'(got), 128'(e.p));
                if (stream_mode) chk("stream_latency", 128'(cyc), 128'(e.cyc + 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        exe_mem_payload_t z;
        z = mk(32'h0, 32'h0, 3'b000);
        rst = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0;
        wb_in = 0; mr_in = 0; mw_in = 0; alu_in = 0; st_in = 0; pc_in = 0; dest_in = 0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; pay0 = z;
        #1 rst = 1'b1;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_occupancy", 128'(occ), 128'(0));
        chk("rst_alu", 128'(alu), 128'(0));
        chk("rst_in_ready_skid0", 128'(in_ready0), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        // Streaming at full rate.
        stream_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0, mk(32'(i * 4), 32'(i * 3 + 1), 3'(i)));
            chk("stream_in_ready", 128'(in_ready), 128'(1));
        end
        step(1'b0, 1'b1, 1'b0, z);
        stream_mode = 1'b0;
        step(1'b0, 1'b1, 1'b0, z);
        chk("stream_drained_occ", 128'(occ), 128'(0));

        // Back-pressure into the skid slot.
        step(1'b1, 1'b0, 1'b0, mk(32'h20, 32'h200, 3'b100));
        step(1'b1, 1'b0, 1'b0, mk(32'h24, 32'h240, 3'b010));
        step(1'b1, 1'b0, 1'b0, mk(32'h28, 32'h280, 3'b001));
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        chk("bp_occ_two", 128'(occ), 128'(2));
        step(1'b0, 1'b1, 1'b0, z);
        chk("bp_first_pc", 128'(pc), 128'(32'h20));
        chk("bp_in_ready_still_low", 128'(in_ready), 128'(0));
        step(1'b0, 1'b1, 1'b0, z);
        chk("bp_second_pc", 128'(pc), 128'(32'h24));
        chk("bp_second_valid", 128'(out_valid), 128'(1));
        chk("bp_in_ready_rise", 128'(in_ready), 128'(1));
        chk("bp_occ_one", 128'(occ), 128'(1));
        step(1'b0, 1'b1, 1'b0, z);
        chk("bp_empty", 128'(out_valid), 128'(0));

        // Flush beats a simultaneous input; the pending output still completes.
        step(1'b1, 1'b0, 1'b0, mk(32'h30, 32'h1111, 3'b001));
        step(1'b1, 1'b1, 1'b1, mk(32'h34, 32'hDEAD, 3'b001));
        step(1'b0, 1'b1, 1'b0, z);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_mem_w_en", 128'(mw), 128'(0));
        chk("flush_alu_held", 128'(alu), 128'(32'h1111));
        chk("flush_occ", 128'(occ), 128'(0));
        step(1'b0, 1'b1, 1'b0, z);
        chk("flush_stays_empty", 128'(out_valid), 128'(0));

        // Enable gating once the stage empties.
        step(1'b1, 1'b1, 1'b0, mk(32'h50, 32'hBEEF, 3'b111));
        step(1'b0, 1'b1, 1'b0, z);
        chk("gate_mw_valid", 128'(mw), 128'(1));
        step(1'b0, 1'b1, 1'b0, z);
        chk("gate_out_valid", 128'(out_valid), 128'(0));
        chk("gate_ctl", 128'({wb, mr, mw}), 128'(3'b000));
        chk("gate_alu_held", 128'(alu), 128'(32'hBEEF));

        // Asynchronous reset while holding two entries.
        step(1'b1, 1'b0, 1'b0, mk(32'h10, 32'h100, 3'b100));
        step(1'b1, 1'b0, 1'b0, mk(32'h14, 32'h140, 3'b100));
        step(1'b0, 1'b0, 1'b0, z);
        chk("pre_rst_occ", 128'(occ), 128'(2));
        chk("pre_rst_wb", 128'(wb), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_wb", 128'(wb), 128'(0));
        chk("mid_rst_occ", 128'(occ), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_pc", 128'(pc), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // SKID=0: ready is combinational from out_ready.
        @(posedge clk); #1;
        in_valid0 = 1'b1; out_ready0 = 1'b0; pay0 = mk(32'h40, 32'h400, 3'b111);
        @(negedge clk);
        chk("s0_ready_empty", 128'(in_ready0), 128'(1));
        @(posedge clk); #1;
        pay0 = mk(32'h44, 32'h440, 3'b001);
        @(negedge clk);
        chk("s0_out_valid", 128'(out_valid0), 128'(1));
        chk("s0_pc_first", 128'(pc0), 128'(32'h40));
        chk("s0_ready_blocked", 128'(in_ready0), 128'(0));
        chk("s0_occ", 128'(occ0), 128'(1));
        #1 out_ready0 = 1'b1;
        #1 chk("s0_ready_comb", 128'(in_ready0), 128'(1));
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("s0_reload_pc", 128'(pc0), 128'(32'h44));
        chk("s0_reload_valid", 128'(out_valid0), 128'(1));
        chk("s0_occ_max", 128'(occ0), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("s0_drained", 128'(out_valid0), 128'(0));
        chk("s0_mw_gated", 128'(mw0), 128'(0));
        chk("s0_pc_held", 128'(pc0), 128'(32'h44));

        step(1'b0, 1'b1, 1'b0, z);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
